imem_fetch: RTL and testbench

IMEM_FETCH -- requirements
Module: imem_fetch

---
 rtl/riscv_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 54 +++++
 rtl/imem_fetch.sv | 125 ++++++++++++
 tb/tb_imem_fetch.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: fetch FSM state encoding and instruction width.
package riscv_pkg;

  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FULL  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; DEPTH must be a power of two so pointers wrap naturally.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             wr_ok;
  logic             rd_ok;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_CNT);
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a write.
  assign rd_ok   = rd_en && !empty && !flush;
  assign wr_ok   = wr_en && (!full || rd_ok) && !flush;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/imem_fetch.sv
// Instruction fetch from a 2-cycle-latency block memory into a credit-limited output FIFO.
// Optional delivered-instruction counter compiled in with IMEM_FETCH_COUNT_EN.
module imem_fetch
  import riscv_pkg::*;
#(
  parameter int          ADDR_WIDTH = 16,
  parameter int          DATA_WIDTH = INSTR_W,
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [31:0]           out_pc,
  output logic [31:0]           fetch_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_CNT = (CW+1)'(FIFO_DEPTH);

  fetch_state_e state;
  fetch_state_e state_nxt;
  logic [31:0]  pc;
  logic         issue;
  logic         credit;
  logic [CW:0]  occupancy;
  logic         pop;

  logic         vld_p1;
  logic [31:0]  pc_p1;
  logic         vld_p2;
  logic [31:0]  pc_p2;

  logic [CW-1:0]              fifo_count;
  logic                       fifo_empty;
  logic [DATA_WIDTH+31:0]     fifo_head;

  assign mem_rd_addr = pc[ADDR_WIDTH+1:2];
  // Credit counts words already buffered plus words still in the memory pipeline.
  assign occupancy   = {1'b0, fifo_count} + {{CW{1'b0}}, vld_p1} + {{CW{1'b0}}, vld_p2};
  assign credit      = (occupancy < DEPTH_CNT);
  assign issue       = (state == ST_FETCH) && fetch_en && !redirect_valid && credit;
  assign pop         = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    if (redirect_valid) begin
      state_nxt = fetch_en ? ST_FETCH : ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (fetch_en) state_nxt = ST_FETCH;
        ST_FETCH: begin
          if (!fetch_en)    state_nxt = ST_IDLE;
          else if (!credit) state_nxt = ST_FULL;
        end
        ST_FULL: begin
          if (!fetch_en)   state_nxt = ST_IDLE;
          else if (credit) state_nxt = ST_FETCH;
        end
        default:          state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= ST_IDLE;
      pc     <= RESET_PC;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      state <= state_nxt;
      if (redirect_valid)  pc <= redirect_pc & 32'hFFFF_FFFC;
      else if (issue)      pc <= pc + 32'd4;
      vld_p1 <= issue;
      vld_p2 <= vld_p1 && !redirect_valid;
    end
  end

  // Stage p1: address issued last cycle; stage p2: memory data valid this cycle
  always_ff @(posedge clk) begin
    pc_p1 <= pc;
    pc_p2 <= pc_p1;
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH + 32)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .flush   (redirect_valid),
    .wr_en   (vld_p2),
    .wr_data ({mem_rd_data, pc_p2}),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign out_instr = out_valid ? fifo_head[DATA_WIDTH+31:32] : '0;
  assign out_pc    = out_valid ? fifo_head[31:0] : '0;

`ifdef IMEM_FETCH_COUNT_EN
  logic [31:0] count_q;

  always_ff @(posedge clk) begin
    if (!rstn)    count_q <= '0;
    else if (pop) count_q <= count_q + 32'd1;
  end

  assign fetch_count = count_q;
`else
  assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_imem_fetch.sv
// Directed table-driven bench for imem_fetch plus hand sequences for reset and address wrap.
module tb_imem_fetch;

  logic        clk = 1'b0;
  logic        rstn;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_ready;

  logic [15:0] mem_rd_addr;
  logic [31:0] mem_rd_data;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] fetch_count;

  logic [3:0]  w_addr;
  logic [31:0] w_rdata;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic [31:0] w_count;

  logic [31:0] rd_d1, rd_d2, w_d1, w_d2;

  int checks = 0;
  int errors = 0;

`ifdef IMEM_FETCH_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  imem_fetch #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .RESET_PC(32'h100), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rstn(rstn), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .fetch_count(fetch_count)
  );

  imem_fetch #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .RESET_PC(32'h38), .FIFO_DEPTH(4)) u_wrap (
    .clk(clk), .rstn(rstn), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .mem_rd_addr(w_addr), .mem_rd_data(w_rdata),
    .out_valid(w_valid), .out_ready(out_ready), .out_instr(w_instr), .out_pc(w_pc),
    .fetch_count(w_count)
  );

  // Block memories: word at address a is 0x60+a (main) and 0xB00+a (wrap), two-cycle latency.
  always @(posedge clk) begin
    rd_d1 <= 32'h60 + {16'h0, mem_rd_addr};
    rd_d2 <= rd_d1;
    w_d1  <= 32'hB00 + {28'h0, w_addr};
    w_d2  <= w_d1;
  end
  assign mem_rd_data = rd_d2;
  assign w_rdata     = w_d2;

  typedef struct {
    logic        rstn, fe, rdy, rv;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc, einstr;
    logic [15:0] eaddr;
    logic [31:0] ecnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic fe, input logic rdy, input logic rv,
                     input logic [31:0] rpc, input logic ev, input logic [31:0] epc,
                     input logic [31:0] einstr, input logic [15:0] eaddr, input logic [31:0] ecnt);
    vec_t v;
    v.rstn = r; v.fe = fe; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.epc = epc; v.einstr = einstr; v.eaddr = eaddr; v.ecnt = ecnt;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic fe, input logic rdy);
    rstn = r; fetch_en = fe; out_ready = rdy; redirect_valid = 1'b0; redirect_pc = '0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; fetch_en = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    // Reset release, one instruction per cycle
    add(0,0,0,0,0, 0,0,0,16'h40,0);
    add(0,1,1,0,0, 0,0,0,16'h40,0);
    add(1,1,1,0,0, 0,0,0,16'h40,0);
    add(1,1,1,0,0, 0,0,0,16'h41,0);
    add(1,1,1,0,0, 0,0,0,16'h42,0);
    add(1,1,1,0,0, 1,32'h100,32'hA0,16'h43,0);
    add(1,1,1,0,0, 1,32'h104,32'hA1,16'h44,1);
    add(1,1,1,0,0, 1,32'h108,32'hA2,16'h45,2);
    add(1,1,1,0,0, 1,32'h10C,32'hA3,16'h46,3);
    add(1,1,1,0,0, 1,32'h110,32'hA4,16'h47,4);
    // Back-pressure for 10 cycles, then drain
    add(0,1,0,0,0, 0,0,0,16'h40,0);
    add(1,1,0,0,0, 0,0,0,16'h40,0);
    add(1,1,0,0,0, 0,0,0,16'h41,0);
    add(1,1,0,0,0, 0,0,0,16'h42,0);
    add(1,1,0,0,0, 1,32'h100,32'hA0,16'h43,0);
    for (int i = 0; i < 6; i++) add(1,1,0,0,0, 1,32'h100,32'hA0,16'h44,0);
    add(1,1,1,0,0, 1,32'h104,32'hA1,16'h44,1);
    add(1,1,1,0,0, 1,32'h108,32'hA2,16'h44,2);
    add(1,1,1,0,0, 1,32'h10C,32'hA3,16'h45,3);
    add(1,1,1,0,0, 0,0,0,16'h46,4);
    add(1,1,1,0,0, 1,32'h110,32'hA4,16'h47,4);
    add(1,1,1,0,0, 1,32'h114,32'hA5,16'h48,5);
    // Redirect to 0x203 with 3 words buffered; pop in redirect cycle counts
    add(0,1,0,0,0, 0,0,0,16'h40,0);
    add(1,1,0,0,0, 0,0,0,16'h40,0);
    add(1,1,0,0,0, 0,0,0,16'h41,0);
    add(1,1,0,0,0, 0,0,0,16'h42,0);
    add(1,1,0,0,0, 1,32'h100,32'hA0,16'h43,0);
    add(1,1,0,0,0, 1,32'h100,32'hA0,16'h44,0);
    add(1,1,0,0,0, 1,32'h100,32'hA0,16'h44,0);
    add(1,1,1,1,32'h203, 0,0,0,16'h80,1);
    add(1,1,1,0,0, 0,0,0,16'h81,1);
    add(1,1,1,0,0, 0,0,0,16'h82,1);
    add(1,1,1,0,0, 1,32'h200,32'hE0,16'h83,1);
    add(1,1,1,0,0, 1,32'h204,32'hE1,16'h84,2);
    add(1,1,1,0,0, 1,32'h208,32'hE2,16'h85,3);
    add(1,1,1,0,0, 1,32'h20C,32'hE3,16'h86,4);
    add(1,1,1,0,0, 1,32'h210,32'hE4,16'h87,5);
    add(1,1,1,0,0, 1,32'h214,32'hE5,16'h88,6);
    add(1,1,1,0,0, 1,32'h218,32'hE6,16'h89,7);
    add(1,1,0,0,0, 1,32'h218,32'hE6,16'h8A,7);

    for (int i = 0; i < tbl.size(); i++) begin
      rstn = tbl[i].rstn; fetch_en = tbl[i].fe; out_ready = tbl[i].rdy;
      redirect_valid = tbl[i].rv; redirect_pc = tbl[i].rpc;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d out_valid", i), {31'h0, out_valid}, {31'h0, tbl[i].ev});
      chk($sformatf("row%0d out_pc", i), out_pc, tbl[i].epc);
      chk($sformatf("row%0d out_instr", i), out_instr, tbl[i].einstr);
      chk($sformatf("row%0d mem_rd_addr", i), {16'h0, mem_rd_addr}, {16'h0, tbl[i].eaddr});
      chk($sformatf("row%0d fetch_count", i), fetch_count, CNT_EN ? tbl[i].ecnt : 32'h0);
    end

    // Reset with 2 words in flight and 2 buffered discards them all
    drive(0, 1, 0);
    for (int k = 0; k < 5; k++) drive(1, 1, 0);
    chk("midrst pre out_pc", out_pc, 32'h100);
    drive(0, 1, 1);
    chk("midrst out_valid", {31'h0, out_valid}, 32'h0);
    chk("midrst out_pc", out_pc, 32'h0);
    chk("midrst out_instr", out_instr, 32'h0);
    chk("midrst mem_rd_addr", {16'h0, mem_rd_addr}, 32'h40);
    chk("midrst fetch_count", fetch_count, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      drive(1, 1, 1);
      chk($sformatf("midrst refetch gap%0d", k), {31'h0, out_valid}, 32'h0);
    end
    drive(1, 1, 1);
    chk("midrst first out_pc", out_pc, 32'h100);
    chk("midrst first out_instr", out_instr, 32'hA0);
    drive(1, 1, 1);
    chk("midrst second out_pc", out_pc, 32'h104);

    // Narrow address: word address wraps 15 -> 0 while byte pc keeps counting
    drive(0, 1, 1);
    for (int k = 1; k <= 6; k++) begin
      logic [3:0] ea;
      drive(1, 1, 1);
      ea = 4'(13 + k);
      chk($sformatf("wrap addr e%0d", k), {28'h0, w_addr}, {28'h0, ea});
      if (k == 4) begin
        chk("wrap out_pc 0x38", w_pc, 32'h38);
        chk("wrap out_instr 0x38", w_instr, 32'hB0E);
      end else if (k == 5) begin
        chk("wrap out_pc 0x3C", w_pc, 32'h3C);
        chk("wrap out_instr 0x3C", w_instr, 32'hB0F);
      end else if (k == 6) begin
        chk("wrap out_pc 0x40", w_pc, 32'h40);
        chk("wrap out_instr 0x40", w_instr, 32'hB00);
        chk("wrap out_valid", {31'h0, w_valid}, 32'h1);
      end
    end
    chk("wrap fetch_count", w_count, CNT_EN ? 32'd2 : 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
